// File: rtl/sum_split.sv
`default_nettype none
// ============================================================================
//  Module      : sum_split
//  Description : Splits a 16-bit unsigned total into a stream of byte beats.
//                Each beat carries at most CHUNK_MAX. The last beat is
//                flagged, and a one-cycle done pulse follows its acceptance.
//                Abort cancels a split that is in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_split #(
    parameter logic [7:0] CHUNK_MAX = 8'hFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] total,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        abort,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        data_last,
    output logic        done
);

    localparam logic [15:0] c_chunk16 = {8'd0, CHUNK_MAX};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_remaining;
    logic [7:0]  r_data;
    logic        r_data_valid;
    logic        r_data_last;
    logic        r_load_ready;
    logic        r_done;

    logic        w_xfer;
    logic [15:0] w_rem_next;
    logic [7:0]  w_load_beat;
    logic        w_load_last;
    logic [7:0]  w_next_beat;
    logic        w_next_last;

    // The beat handshake completes when the presented beat is taken downstream.
    assign w_xfer      = r_data_valid && data_ready;
    // w_rem_next never underflows because a beat is never larger than the remaining amount.
    assign w_rem_next  = r_remaining - {8'd0, r_data};

    // The first beat is precomputed from the incoming total, so the outputs stay registered.
    assign w_load_beat = (total > c_chunk16) ? CHUNK_MAX : total[7:0];
    assign w_load_last = (total <= c_chunk16);

    // The following beat is precomputed from the amount left after the current transfer.
    assign w_next_beat = (w_rem_next > c_chunk16) ? CHUNK_MAX : w_rem_next[7:0];
    assign w_next_last = (w_rem_next <= c_chunk16);

    // Control FSM with registered outputs. Abort takes priority over load and over transfer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_remaining  <= 16'd0;
            r_data       <= 8'd0;
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
            r_load_ready <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_valid && r_load_ready && !abort) begin
                        r_state      <= SEND;
                        r_remaining  <= total;
                        r_data       <= w_load_beat;
                        r_data_last  <= w_load_last;
                        r_data_valid <= 1'b1;
                        r_load_ready <= 1'b0;
                    end
                end
                SEND: begin
                    if (abort) begin
                        r_state      <= IDLE;
                        r_remaining  <= 16'd0;
                        r_data       <= 8'd0;
                        r_data_last  <= 1'b0;
                        r_data_valid <= 1'b0;
                        r_load_ready <= 1'b1;
                    end else if (w_xfer) begin
                        if (r_data_last) begin
                            r_state      <= IDLE;
                            r_remaining  <= 16'd0;
                            r_data       <= 8'd0;
                            r_data_last  <= 1'b0;
                            r_data_valid <= 1'b0;
                            r_load_ready <= 1'b1;
                            r_done       <= 1'b1;
                        end else begin
                            r_remaining  <= w_rem_next;
                            r_data       <= w_next_beat;
                            r_data_last  <= w_next_last;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_remaining  <= 16'd0;
                    r_data       <= 8'd0;
                    r_data_last  <= 1'b0;
                    r_data_valid <= 1'b0;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign data_last  = r_data_last;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sum_split.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_split
//  Description : Scoreboard bench for sum_split. Two instances are used, with
//                CHUNK_MAX set to 255 and to 100. The driver pushes the
//                expected beats of each split. The negedge monitor pops and
//                compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_split;

    localparam int C0 = 255;
    localparam int C1 = 100;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] total      [2];
    logic        load_valid [2];
    logic        load_ready [2];
    logic        abort      [2];
    logic [7:0]  data       [2];
    logic        data_valid [2];
    logic        data_ready [2];
    logic        data_last  [2];
    logic        done       [2];

    int checks   = 0;
    int failures = 0;

    // Scoreboard: each entry is {last, data} packed as last*256 + data.
    int exp_q [2][$];
    int tot_q [2][$];
    int n_q   [2][$];

    bit         pend_done [2] = '{0, 0};
    bit         hold_v    [2] = '{0, 0};
    logic [7:0] hold_d    [2];
    logic       hold_l    [2];
    int         sum_b     [2] = '{0, 0};
    int         beat_n    [2] = '{0, 0};
    int         xfer_cnt  [2] = '{0, 0};
    int         rmode     [2];

    always #5 CLK = ~CLK;

    sum_split #(.CHUNK_MAX(8'd255)) u_dut0 (
        .CLK(CLK), .RST(RST), .total(total[0]), .load_valid(load_valid[0]),
        .load_ready(load_ready[0]), .abort(abort[0]), .data(data[0]),
        .data_valid(data_valid[0]), .data_ready(data_ready[0]),
        .data_last(data_last[0]), .done(done[0])
    );

    sum_split #(.CHUNK_MAX(8'd100)) u_dut1 (
        .CLK(CLK), .RST(RST), .total(total[1]), .load_valid(load_valid[1]),
        .load_ready(load_ready[1]), .abort(abort[1]), .data(data[1]),
        .data_valid(data_valid[1]), .data_ready(data_ready[1]),
        .data_last(data_last[1]), .done(done[1])
    );

    function automatic int cmax(input int k);
        return (k == 0) ? C0 : C1;
    endfunction

    // Reference model: ceil(total/C) beats, all C except the remainder on the last beat.
    task automatic push_expect(input int k, input int tot);
        int c;
        int n;
        int b;
        c = cmax(k);
        n = (tot == 0) ? 1 : (tot + c - 1) / c;
        for (int i = 0; i < n; i++) begin
            b = (i < n - 1) ? c : tot - c * (n - 1);
            exp_q[k].push_back(((i == n - 1) ? 256 : 0) + b);
        end
        tot_q[k].push_back(tot);
        n_q[k].push_back(n);
    endtask

    // Monitor: checks reset values, handshake invariants, stability, beats, sums and done.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                checks++;
                if (data_valid[k] || data_last[k] || done[k] || data[k] != 8'd0 || !load_ready[k]) begin
                    failures++;
                    $display("FAIL reset_outputs inst%0d got v=%0b l=%0b d=%0d done=%0b lr=%0b required 0,0,0,0,1",
                             k, data_valid[k], data_last[k], data[k], done[k], load_ready[k]);
                end
                exp_q[k].delete();
                tot_q[k].delete();
                n_q[k].delete();
                pend_done[k] = 0;
                hold_v[k]    = 0;
                sum_b[k]     = 0;
                beat_n[k]    = 0;
            end else begin
                checks++;
                if (done[k] !== pend_done[k]) begin
                    failures++;
                    $display("FAIL done_pulse inst%0d got=%0b required=%0b", k, done[k], pend_done[k]);
                end
                pend_done[k] = 0;

                checks++;
                if (load_ready[k] !== !data_valid[k]) begin
                    failures++;
                    $display("FAIL ready_valid_excl inst%0d load_ready=%0b data_valid=%0b", k, load_ready[k], data_valid[k]);
                end

                if (hold_v[k]) begin
                    checks++;
                    if (!data_valid[k] || data[k] !== hold_d[k] || data_last[k] !== hold_l[k]) begin
                        failures++;
                        $display("FAIL stall_stable inst%0d got v=%0b d=%0d l=%0b required v=1 d=%0d l=%0b",
                                 k, data_valid[k], data[k], data_last[k], hold_d[k], hold_l[k]);
                    end
                    hold_v[k] = 0;
                end

                if (!data_valid[k]) begin
                    checks++;
                    if (data[k] !== 8'd0 || data_last[k] !== 1'b0) begin
                        failures++;
                        $display("FAIL idle_zero inst%0d got d=%0d l=%0b required 0,0", k, data[k], data_last[k]);
                    end
                end else if (abort[k]) begin
                    exp_q[k].delete();
                    tot_q[k].delete();
                    n_q[k].delete();
                    sum_b[k]  = 0;
                    beat_n[k] = 0;
                end else if (data_ready[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        failures++;
                        $display("FAIL spurious_beat inst%0d got d=%0d l=%0b required no beat", k, data[k], data_last[k]);
                    end else begin
                        int         e;
                        logic [7:0] ed;
                        logic       el;
                        e  = exp_q[k].pop_front();
                        ed = 8'(e % 256);
                        el = (e >= 256);
                        if (data[k] !== ed || data_last[k] !== el) begin
                            failures++;
                            $display("FAIL beat inst%0d got d=%0d l=%0b required d=%0d l=%0b",
                                     k, data[k], data_last[k], ed, el);
                        end
                    end
                    sum_b[k]  += int'(data[k]);
                    beat_n[k] += 1;
                    xfer_cnt[k] += 1;
                    if (data_last[k]) begin
                        pend_done[k] = 1;
                        if (tot_q[k].size() != 0) begin
                            int t;
                            int nn;
                            t  = tot_q[k].pop_front();
                            nn = n_q[k].pop_front();
                            checks++;
                            if (sum_b[k] != t || beat_n[k] != nn) begin
                                failures++;
                                $display("FAIL split_sum inst%0d got sum=%0d beats=%0d required sum=%0d beats=%0d",
                                         k, sum_b[k], beat_n[k], t, nn);
                            end
                        end
                        sum_b[k]  = 0;
                        beat_n[k] = 0;
                    end
                end else begin
                    hold_v[k] = 1;
                    hold_d[k] = data[k];
                    hold_l[k] = data_last[k];
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rmode[k] == 1)      data_ready[k] = 1'($urandom_range(0, 1));
            else if (rmode[k] == 0) data_ready[k] = 1'b1;
        end
    endtask

    task automatic do_load(input int k, input int tot);
        int guard;
        guard = 0;
        while (!load_ready[k] && guard < 1000) begin
            tick();
            guard++;
        end
        checks++;
        if (!load_ready[k]) begin
            failures++;
            $display("FAIL load_wait inst%0d load_ready=%0b required=1", k, load_ready[k]);
        end
        total[k]      = 16'(tot);
        load_valid[k] = 1'b1;
        push_expect(k, tot);
        tick();
        load_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int guard;
        guard = 0;
        while ((exp_q[k].size() != 0 || pend_done[k]) && guard < 3000) begin
            tick();
            guard++;
        end
        checks++;
        if (exp_q[k].size() != 0 || pend_done[k]) begin
            failures++;
            $display("FAIL split_timeout inst%0d pending=%0d required=0", k, exp_q[k].size());
        end
    endtask

    task automatic wait_xfer(input int k, input int target);
        int guard;
        guard = 0;
        while (xfer_cnt[k] < target && guard < 1000) begin
            tick();
            guard++;
        end
        checks++;
        if (xfer_cnt[k] < target) begin
            failures++;
            $display("FAIL xfer_timeout inst%0d got=%0d required=%0d", k, xfer_cnt[k], target);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int r;
        int k;
        int tot;
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total[i]      = 16'd0;
            load_valid[i] = 1'b0;
            abort[i]      = 1'b0;
            data_ready[i] = 1'b1;
            rmode[i]      = 0;
        end
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Basic splits: 255,255,90 / single zero beat / 100,100,50.
        do_load(0, 600);
        wait_done(0);
        do_load(0, 0);
        wait_done(0);
        do_load(1, 250);
        wait_done(1);

        // First beat stalled for three cycles.
        rmode[0]      = 2;
        data_ready[0] = 1'b0;
        do_load(0, 300);
        tick();
        tick();
        tick();
        data_ready[0] = 1'b1;
        rmode[0]      = 0;
        wait_done(0);

        // Abort in IDLE together with a load: the load must be ignored.
        total[1]      = 16'd50;
        load_valid[1] = 1'b1;
        abort[1]      = 1'b1;
        tick();
        load_valid[1] = 1'b0;
        abort[1]      = 1'b0;
        tick();
        tick();
        tick();

        // Abort together with an accepted beat, then a clean split.
        base = xfer_cnt[1];
        do_load(1, 250);
        wait_xfer(1, base + 1);
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        tick();
        tick();
        do_load(1, 250);
        wait_done(1);

        // Reset mid-split after two beats, then a fresh single-beat split.
        base = xfer_cnt[0];
        do_load(0, 1000);
        wait_xfer(0, base + 2);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        do_load(0, 10);
        wait_done(0);

        // Full-scale total.
        do_load(0, 65535);
        wait_done(0);

        // Randomized totals and backpressure on both instances.
        for (int it = 0; it < 30; it++) begin
            k        = int'($urandom_range(0, 1));
            rmode[k] = 1;
            r        = int'($urandom_range(0, 3));
            case (r)
                0:       tot = int'($urandom_range(0, 5));
                1:       tot = cmax(k) - 1 + int'($urandom_range(0, 2));
                2:       tot = int'($urandom_range(0, 2000));
                default: tot = cmax(k) * int'($urandom_range(1, 5));
            endcase
            do_load(k, tot);
            wait_done(k);
            rmode[k] = 0;
        end

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
